// File: rtl/warp_scalar_reg_file_pkg.sv
// Shared types and reset-pattern helpers for the warp scalar register file.
// DATA_WIDTH defaults to 32 unless the build provides its own `DATA_WIDTH.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_scalar_reg_file_pkg;

  typedef logic [`DATA_WIDTH-1:0] data_t;
  typedef logic [15:0] instruction_memory_address_t;

  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    IMMEDIATE        = 3'd1,
    PC_PLUS_1        = 3'd2,
    VECTOR_TO_SCALAR = 3'd3,
    LSU_OUT          = 3'd4
  } reg_input_mux_t;

  // Register 1 and the execution-mask register come out of reset as all ones.
  localparam int unsigned RF_ONES_REG = 1;

  function automatic logic reset_to_ones(input int unsigned idx, input int unsigned num_regs);
    return (idx == RF_ONES_REG) || (idx == num_regs - 1);
  endfunction

endpackage

// File: rtl/warp_scalar_reg_file_scoreboard.sv
// Per-warp pending-load bits: set by load issue, cleared by LSU writeback.
// A same-cycle set beats a clear of the same bit; register 0 is never marked.
module warp_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 32,
  parameter int WW        = 2,
  parameter int RW        = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [WW-1:0] set_warp,
  input  logic [RW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [WW-1:0] clr_warp,
  input  logic [RW-1:0] clr_addr,
  input  logic [WW-1:0] q_warp,
  input  logic [RW-1:0] q_addr_a,
  input  logic [RW-1:0] q_addr_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [NUM_REGS-1:0] pend_q [NUM_WARPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) pend_q[w] <= '0;
    end else begin
      if (clr_en) pend_q[clr_warp][clr_addr] <= 1'b0;
      if (set_en && (set_addr != '0)) pend_q[set_warp][set_addr] <= 1'b1;
    end
  end

  assign busy_a = pend_q[q_warp][q_addr_a];
  assign busy_b = pend_q[q_warp][q_addr_b];

endmodule

// File: rtl/warp_scalar_reg_file.sv
// Per-warp scalar register file: one registered read pair, execute write port A,
// LSU write port B (wins on collision), load scoreboard. Option: SCALAR_RF_BYPASS_EN.
module warp_scalar_reg_file
  import warp_scalar_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_en,
  input  logic [WW-1:0]                   rd_warp,
  input  logic [RW-1:0]                   rs1_addr,
  input  logic [RW-1:0]                   rs2_addr,
  output logic [DATA_WIDTH-1:0]           rs1,
  output logic [DATA_WIDTH-1:0]           rs2,
  output logic                            src_busy,
  input  logic                            wa_en,
  input  logic [WW-1:0]                   wa_warp,
  input  logic [RW-1:0]                   wa_addr,
  input  reg_input_mux_t                  wa_mux,
  input  logic [DATA_WIDTH-1:0]           alu_out,
  input  logic [DATA_WIDTH-1:0]           decoded_immediate,
  input  logic [DATA_WIDTH-1:0]           vector_to_scalar_data,
  input  instruction_memory_address_t     pc,
  input  logic                            wb_en,
  input  logic [WW-1:0]                   wb_warp,
  input  logic [RW-1:0]                   wb_addr,
  input  logic [DATA_WIDTH-1:0]           wb_data,
  input  logic                            sb_set_en,
  input  logic [WW-1:0]                   sb_set_warp,
  input  logic [RW-1:0]                   sb_set_addr,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_mask,
  input  logic [WW-1:0]                   debug_warp,
  input  logic [RW-1:0]                   debug_reg_addr,
  output logic [DATA_WIDTH-1:0]           debug_reg_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_WARPS][NUM_REGS];
  logic [DATA_WIDTH-1:0] rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] rs1_d, rs2_d;
  logic [DATA_WIDTH-1:0] wa_data;
  logic                  wa_src_valid;
  logic                  wa_we, wb_we;
  logic                  busy_a, busy_b;

  always_comb begin
    wa_data      = '0;
    wa_src_valid = 1'b0;
    case (wa_mux)
      ALU_OUT:          begin wa_data = alu_out;                wa_src_valid = 1'b1; end
      IMMEDIATE:        begin wa_data = decoded_immediate;      wa_src_valid = 1'b1; end
      PC_PLUS_1:        begin wa_data = DATA_WIDTH'(pc) + DATA_WIDTH'(1); wa_src_valid = 1'b1; end
      VECTOR_TO_SCALAR: begin wa_data = vector_to_scalar_data;  wa_src_valid = 1'b1; end
      default:          ;
    endcase
  end

  assign wa_we = wa_en & wa_src_valid & (wa_addr != '0);
  assign wb_we = wb_en & (wb_addr != '0);

  always_comb begin
    rs1_d = regs_q[rd_warp][rs1_addr];
    rs2_d = regs_q[rd_warp][rs2_addr];
`ifdef SCALAR_RF_BYPASS_EN
    // Port B is checked last so it overrides port A, matching write priority.
    if (wa_we && (wa_warp == rd_warp) && (wa_addr == rs1_addr)) rs1_d = wa_data;
    if (wa_we && (wa_warp == rd_warp) && (wa_addr == rs2_addr)) rs2_d = wa_data;
    if (wb_we && (wb_warp == rd_warp) && (wb_addr == rs1_addr)) rs1_d = wb_data;
    if (wb_we && (wb_warp == rd_warp) && (wb_addr == rs2_addr)) rs2_d = wb_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          regs_q[w][r] <= reset_to_ones(r, NUM_REGS) ? '1 : '0;
        end
      end
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      if (wa_we) regs_q[wa_warp][wa_addr] <= wa_data;
      if (wb_we) regs_q[wb_warp][wb_addr] <= wb_data;
      if (rd_en) begin
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
      end
    end
  end

  warp_scoreboard #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_REGS  (NUM_REGS),
    .WW        (WW),
    .RW        (RW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set_en),
    .set_warp (sb_set_warp),
    .set_addr (sb_set_addr),
    .clr_en   (wb_we),
    .clr_warp (wb_warp),
    .clr_addr (wb_addr),
    .q_warp   (rd_warp),
    .q_addr_a (rs1_addr),
    .q_addr_b (rs2_addr),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  assign rs1            = rs1_q;
  assign rs2            = rs2_q;
  assign src_busy       = rd_en & ~reset & (busy_a | busy_b);
  assign debug_reg_data = regs_q[debug_warp][debug_reg_addr];

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_mask
    assign warp_execution_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs_q[w][NUM_REGS-1];
  end

endmodule

// File: tb/tb_warp_scalar_reg_file.sv
// Bench for warp_scalar_reg_file: read results flow through an expected queue
// checked one cycle after each accepted read; other outputs are checked inline.
module tb_warp_scalar_reg_file;
  import warp_scalar_reg_file_pkg::*;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NR = 32;
  localparam logic [DW-1:0] ONES = '1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rd_en;
  logic [1:0]           rd_warp;
  logic [4:0]           rs1_addr, rs2_addr;
  logic [DW-1:0]        rs1, rs2;
  logic                 src_busy;
  logic                 wa_en;
  logic [1:0]           wa_warp;
  logic [4:0]           wa_addr;
  reg_input_mux_t       wa_mux;
  logic [DW-1:0]        alu_out, decoded_immediate, vector_to_scalar_data;
  instruction_memory_address_t pc;
  logic                 wb_en;
  logic [1:0]           wb_warp;
  logic [4:0]           wb_addr;
  logic [DW-1:0]        wb_data;
  logic                 sb_set_en;
  logic [1:0]           sb_set_warp;
  logic [4:0]           sb_set_addr;
  logic [NW*DW-1:0]     warp_execution_mask;
  logic [1:0]           debug_warp;
  logic [4:0]           debug_reg_addr;
  logic [DW-1:0]        debug_reg_data;

  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0] model [NW][NR];

  warp_scalar_reg_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_warp(rd_warp),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1(rs1), .rs2(rs2), .src_busy(src_busy),
    .wa_en(wa_en), .wa_warp(wa_warp), .wa_addr(wa_addr), .wa_mux(wa_mux),
    .alu_out(alu_out), .decoded_immediate(decoded_immediate),
    .vector_to_scalar_data(vector_to_scalar_data), .pc(pc),
    .wb_en(wb_en), .wb_warp(wb_warp), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_warp(sb_set_warp), .sb_set_addr(sb_set_addr),
    .warp_execution_mask(warp_execution_mask),
    .debug_warp(debug_warp), .debug_reg_addr(debug_reg_addr), .debug_reg_data(debug_reg_data)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: each read accepted on an edge is compared one step later
  always @(posedge clk) begin
    logic fire;
    logic [2*DW-1:0] exp;
    fire = rd_en && !reset;
    #1;
    if (fire) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got rs1=%h rs2=%h, required no read result", rs1, rs2);
      end else begin
        exp = exp_q.pop_front();
        if ({rs1, rs2} !== exp) begin
          errors++;
          $display("FAIL read_data: got rs1=%h rs2=%h, required rs1=%h rs2=%h",
                   rs1, rs2, exp[2*DW-1:DW], exp[DW-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 0; rd_warp = 0; rs1_addr = 0; rs2_addr = 0;
    wa_en = 0; wa_warp = 0; wa_addr = 0; wa_mux = ALU_OUT;
    alu_out = 0; decoded_immediate = 0; vector_to_scalar_data = 0; pc = 0;
    wb_en = 0; wb_warp = 0; wb_addr = 0; wb_data = 0;
    sb_set_en = 0; sb_set_warp = 0; sb_set_addr = 0;
    debug_warp = 0; debug_reg_addr = 0;
  endtask

  task automatic model_init();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NR; r++)
        model[w][r] = (r == 1 || r == NR - 1) ? ONES : '0;
  endtask

  task automatic drive_read(input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    rd_en = 1; rd_warp = w; rs1_addr = a1; rs2_addr = a2;
    exp_q.push_back({e1, e2});
  endtask

  task automatic drive_wa(input logic [1:0] w, input logic [4:0] a, input reg_input_mux_t m);
    wa_en = 1; wa_warp = w; wa_addr = a; wa_mux = m;
  endtask

  task automatic drive_wb(input logic [1:0] w, input logic [4:0] a, input logic [DW-1:0] d);
    wb_en = 1; wb_warp = w; wb_addr = a; wb_data = d;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    model_init();
  endtask

  // Tests
  task automatic test_reset();
    idle();
    reset = 1;
    rd_en = 1; rd_warp = 2; rs1_addr = 7; rs2_addr = 31;
    drive_wa(0, 5, ALU_OUT); alu_out = 32'h1111_2222;
    drive_wb(0, 6, 32'h3333_4444);
    sb_set_en = 1; sb_set_warp = 2; sb_set_addr = 7;
    step(); step();
    #1;
    checks++; if (rs1 !== '0) begin errors++; $display("FAIL reset_rs1: got %h, required 0", rs1); end
    checks++; if (rs2 !== '0) begin errors++; $display("FAIL reset_rs2: got %h, required 0", rs2); end
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", src_busy); end
    reset = 0;
    idle();
    model_init();
    checks++;
    if (warp_execution_mask !== {NW*DW{1'b1}}) begin
      errors++; $display("FAIL reset_mask: got %h, required all ones", warp_execution_mask);
    end
    debug_warp = 0; debug_reg_addr = 5; #1;
    checks++; if (debug_reg_data !== '0) begin errors++; $display("FAIL reset_write_ignored: got %h, required 0", debug_reg_data); end
    drive_read(2, 1, 31, ONES, ONES);
    step();
    drive_read(2, 7, 0, 32'h0, 32'h0);
    #1;
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL reset_sb_ignored: got %b, required 0", src_busy); end
    step();
    idle();
  endtask

  task automatic test_write_priority();
    idle();
    drive_wa(1, 5, ALU_OUT); alu_out = 32'h1234;
    drive_wb(1, 5, 32'hBEEF);
    step(); idle();
    drive_wa(1, 6, ALU_OUT); alu_out = 32'h1111;
    drive_wb(1, 7, 32'h2222);
    step(); idle();
    drive_wa(1, 0, ALU_OUT); alu_out = 32'hDEAD;
    drive_wb(1, 0, 32'hCAFE);
    step(); idle();
    drive_read(1, 5, 0, 32'hBEEF, 32'h0);
    step();
    drive_read(1, 6, 7, 32'h1111, 32'h2222);
    step();
    drive_read(2, 5, 1, 32'h0, ONES);
    step();
    idle();
    debug_warp = 1; debug_reg_addr = 0; #1;
    checks++; if (debug_reg_data !== '0) begin errors++; $display("FAIL r0_debug: got %h, required 0", debug_reg_data); end
  endtask

  task automatic test_mux();
    idle();
    alu_out = 32'hA1; decoded_immediate = 32'hA2; vector_to_scalar_data = 32'hA3; pc = 16'h007F;
    drive_wa(0, 3, PC_PLUS_1); step();
    drive_wa(0, 3, LSU_OUT); step();
    drive_wa(0, 3, reg_input_mux_t'(3'd7)); step();
    drive_wa(0, 4, IMMEDIATE); step();
    drive_wa(0, 8, VECTOR_TO_SCALAR); step();
    idle();
    drive_read(0, 3, 4, 32'h80, 32'hA2);
    step();
    drive_read(0, 8, 2, 32'hA3, 32'h0);
    step();
    idle();
  endtask

  task automatic test_hold();
    idle();
    drive_read(0, 3, 4, 32'h80, 32'hA2);
    step();
    rd_en = 0; rs1_addr = 8; rs2_addr = 1;
    step(); step();
    checks++;
    if (rs1 !== 32'h80 || rs2 !== 32'hA2) begin
      errors++; $display("FAIL read_hold: got rs1=%h rs2=%h, required rs1=80 rs2=a2", rs1, rs2);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set_en = 1; sb_set_warp = 3; sb_set_addr = 7;
    step(); idle();
    drive_read(3, 7, 0, 32'h0, 32'h0); #1;
    checks++; if (src_busy !== 1'b1) begin errors++; $display("FAIL sb_set_busy: got %b, required 1", src_busy); end
    step();
    rd_en = 0; rd_warp = 3; rs1_addr = 7; #1;
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL sb_no_read: got %b, required 0", src_busy); end
    drive_read(2, 7, 0, 32'h0, 32'h0); #1;
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL sb_other_warp: got %b, required 0", src_busy); end
    step(); idle();
    drive_wb(3, 7, 32'h77);
    step(); idle();
    drive_read(3, 0, 7, 32'h0, 32'h77); #1;
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b, required 0", src_busy); end
    step(); idle();
    sb_set_en = 1; sb_set_warp = 3; sb_set_addr = 7;
    drive_wb(3, 7, 32'h78);
    step(); idle();
    drive_read(3, 0, 7, 32'h0, 32'h78); #1;
    checks++; if (src_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b, required 1", src_busy); end
    step(); idle();
    sb_set_en = 1; sb_set_warp = 3; sb_set_addr = 0;
    step(); idle();
    drive_read(3, 0, 0, 32'h0, 32'h0); #1;
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL sb_r0: got %b, required 0", src_busy); end
    step(); idle();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] e_a, e_b;
`ifdef SCALAR_RF_BYPASS_EN
    e_a = 32'hA5; e_b = 32'h22;
`else
    e_a = 32'h0;  e_b = 32'h0;
`endif
    idle();
    drive_wa(0, 9, ALU_OUT); alu_out = 32'hA5;
    drive_read(0, 9, 1, e_a, ONES);
    debug_warp = 0; debug_reg_addr = 9; #1;
    checks++; if (debug_reg_data !== 32'h0) begin errors++; $display("FAIL debug_no_bypass: got %h, required 0", debug_reg_data); end
    step(); idle();
    drive_read(0, 9, 9, 32'hA5, 32'hA5);
    step(); idle();
    drive_wa(0, 10, ALU_OUT); alu_out = 32'h11;
    drive_wb(0, 10, 32'h22);
    drive_read(0, 1, 10, ONES, e_b);
    step(); idle();
    drive_read(0, 10, 0, 32'h22, 32'h0);
    step(); idle();
  endtask

  task automatic test_reset_midstream();
    logic [NW*DW-1:0] exp_mask;
    idle();
    drive_wa(1, 31, IMMEDIATE); decoded_immediate = 32'h0000_000F;
    step(); idle();
    exp_mask = {ONES, ONES, 32'h0000_000F, ONES};
    checks++;
    if (warp_execution_mask !== exp_mask) begin
      errors++; $display("FAIL mask_update: got %h, required %h", warp_execution_mask, exp_mask);
    end
    sb_set_en = 1; sb_set_warp = 2; sb_set_addr = 4;
    step(); idle();
    drive_read(2, 4, 1, 32'h0, ONES);
    step();
    reset = 1;
    rd_en = 1; rd_warp = 2; rs1_addr = 4; rs2_addr = 1;
    drive_wa(1, 31, ALU_OUT); alu_out = 32'h3;
    step(); #1;
    checks++; if (rs1 !== '0 || rs2 !== '0) begin errors++; $display("FAIL midreset_rs: got rs1=%h rs2=%h, required 0 0", rs1, rs2); end
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", src_busy); end
    step();
    reset = 0; idle();
    model_init();
    checks++;
    if (warp_execution_mask !== {NW*DW{1'b1}}) begin
      errors++; $display("FAIL midreset_mask: got %h, required all ones", warp_execution_mask);
    end
    drive_read(2, 4, 31, 32'h0, ONES); #1;
    checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL midreset_sb: got %b, required 0", src_busy); end
    step(); idle();
  endtask

  task automatic test_random();
    logic [1:0] w;
    logic [4:0] a, a2;
    logic [DW-1:0] d;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      idle();
      w = 2'($urandom_range(0, NW - 1));
      a = 5'($urandom_range(0, NR - 1));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        drive_wb(w, a, d);
      end else begin
        drive_wa(w, a, ALU_OUT); alu_out = d;
      end
      if (a != 0) model[w][a] = d;
      step(); idle();
      a2 = 5'($urandom_range(0, NR - 1));
      drive_read(w, a, a2, model[w][a], model[w][a2]);
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    model_init();
    test_reset();
    test_write_priority();
    test_mux();
    test_hold();
    test_scoreboard();
    test_bypass();
    test_reset_midstream();
    test_random();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL queue_drain: got %0d pending reads, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_scalar_reg_file.md
WARP_SCALAR_REG_FILE -- requirements
Module: warp_scalar_reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), register data width.
REQ-002 SHALL have parameter NUM_WARPS, default 4, number of warps with private register sets; power of two, 1..16.
REQ-003 SHALL have parameter NUM_REGS, default 32, registers per warp; power of two, 8..32; index NUM_REGS-1 is the execution-mask register.
REQ-004 SHALL have ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  1  read request.
- rd_warp  in  WW=clog2(NUM_WARPS)  warp being read.
- rs1_addr, rs2_addr  in  RW=clog2(NUM_REGS)  source indices.
- rs1, rs2  out  DATA_WIDTH  registered read data.
- src_busy  out  1  a source of the current request has a pending load (combinational).
- wa_en, wa_warp, wa_addr, wa_mux  in  1/WW/RW/reg_input_mux_t  port A write (execute results).
- alu_out, decoded_immediate, vector_to_scalar_data  in  DATA_WIDTH each  port A sources.
- pc  in  instruction_memory_address_t  port A PC_PLUS_1 source.
- wb_en, wb_warp, wb_addr, wb_data  in  1/WW/RW/DATA_WIDTH  port B write (LSU writeback).
- sb_set_en, sb_set_warp, sb_set_addr  in  1/WW/RW  mark register pending a load.
- warp_execution_mask  out  NUM_WARPS*DATA_WIDTH  register NUM_REGS-1 of each warp, warp 0 in LSBs.
- debug_warp, debug_reg_addr  in  WW/RW;  debug_reg_data  out  DATA_WIDTH  combinational peek.

Function
REQ-005 SHALL store NUM_WARPS x NUM_REGS words; register 0 of every warp always reads zero and ignores writes and scoreboard sets.
REQ-006 SHALL register rs1/rs2 on the clk edge where rd_en=1 (latency 1); hold previous values when rd_en=0.
REQ-007 SHALL write port A on the clk edge where wa_en=1 and wa_addr!=0, with data selected by wa_mux: ALU_OUT->alu_out, IMMEDIATE->decoded_immediate, PC_PLUS_1->pc+1 zero-extended, VECTOR_TO_SCALAR->vector_to_scalar_data; LSU_OUT or any other value -> no write.
REQ-008 SHALL write port B (wb_data) on the clk edge where wb_en=1 and wb_addr!=0, and clear that register's scoreboard bit.
REQ-009 SHALL give port B priority when both ports target the same warp and register in one cycle; writes to different registers both commit.
REQ-010 SHALL set the scoreboard bit on sb_set_en; set wins over a same-cycle port B clear of the same bit.
REQ-011 SHALL drive src_busy=rd_en & (scoreboard[rd_warp][rs1_addr] | scoreboard[rd_warp][rs2_addr]) from current state; the block never stalls itself.
REQ-012 SHALL reflect execution-mask writes on warp_execution_mask the cycle after the write edge.
REQ-013 SHALL return debug_reg_data from stored state, unaffected by bypass.

Reset
REQ-014 SHALL, on reset, set register 1 and register NUM_REGS-1 of every warp to all ones, all other registers to zero, and all scoreboard bits to zero.
REQ-015 SHALL drive rs1=rs2=0 and src_busy=0 while reset is high and ignore all write, read and scoreboard inputs; a load pending at reset is discarded.

Configuration
REQ-016 With SCALAR_RF_BYPASS_EN defined, a read and a write to the same warp/register in one cycle SHALL return the new data (port B over port A); without it the read SHALL return the pre-write value.

Structure
REQ-017 reg_input_mux_t, data_t, instruction_memory_address_t and the reset-pattern constants SHALL come from the shared common package; no new package types.
REQ-018 The scoreboard SHALL be a sub-module warp_scoreboard (NUM_WARPS x NUM_REGS bits, set/clear/query); storage and bypass stay in this module.

Verification
REQ-019 Reset, then read warp 2 regs 1 and 31 -> rs1=0xFFFFFFFF, rs2=0xFFFFFFFF one cycle later; warp_execution_mask all ones.
REQ-020 Port A ALU_OUT 0x1234 to warp 1 r5, port B 0xBEEF to warp 1 r5 same cycle -> read returns 0xBEEF; write to r0 -> read 0.
REQ-021 wa_mux=PC_PLUS_1, pc=0x7F to warp 0 r3 -> r3=0x80; wa_mux=LSU_OUT -> r3 unchanged.
REQ-022 sb_set warp 3 r7, read rs1=7 -> src_busy=1; wb to r7 -> src_busy=0 next cycle; set and wb same cycle -> src_busy stays 1.
REQ-023 Read and port A write warp 0 r9=0xA5 same cycle -> rs1=0xA5 with SCALAR_RF_BYPASS_EN, old value without.
REQ-024 Write mask 0x0000000F to warp 1 r31 then assert reset mid-stream -> mask back to all ones, scoreboard clear, rs1/rs2=0 during reset.
